fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage that owns the program counter and drives the byte address into the instruction memory.
- The instruction memory is big-endian, byte-addressed, with a registered read: the address presented in cycle n returns its word in cycle n+1.
- This block tracks that one-cycle latency and presents an aligned {pc, instruction, valid} triple to decode.
- It handles decode stalls, branch/jump redirects with squash, and keeps a fetched-instruction counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned).
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  decode cannot accept the current output; hold it.
- branch_taken  input  1  EX-stage branch redirect.
- branch_target  input  32  byte target for branch_taken.
- jump  input  1  ID-stage jump redirect.
- jump_target  input  32  byte target for jump.
- address  output  32  byte address to instruction memory (combinational).
- instruction_in  input  32  registered read data from instruction memory.
- if_pc  output  32  address of the word on if_instruction.
- if_pc_plus4  output  32  if_pc + 4, modulo 2^32.
- if_instruction  output  32  instruction_in passed through.
- if_valid  output  1  if_instruction is a real, non-squashed instruction.
- misaligned  output  1  sticky: a redirect target had addr[1:0] != 0.
- fetch_count  output  32  number of instructions accepted by decode.

Behaviour:
- State registers:
  - pc: next address to fetch.
  - pc_q: address whose word is on instruction_in this cycle.
  - valid_q.
  - misaligned.
  - fetch_count.
- Reset (rst_n low, asynchronous, any cycle including mid-redirect or mid-stall):
  - pc = pc_q = RESET_PC; valid_q = 0; misaligned = 0; fetch_count = 0.
  - Outputs follow immediately: address = RESET_PC, if_pc = RESET_PC, if_pc_plus4 = RESET_PC + 4, if_valid = 0, misaligned = 0, fetch_count = 0.
- Address mux (combinational), in priority order:
  - branch_taken: {branch_target[31:2], 2'b00}.
  - else jump: {jump_target[31:2], 2'b00}.
  - else stall: pc_q (re-fetch the held word so it is still on instruction_in next cycle).
  - else: pc.
- The redirect path feeds the memory directly, so the target word arrives one cycle after the redirect cycle.
- Update on each rising clk edge:
  - branch_taken (wins over jump and stall): pc_q <= aligned branch target; pc <= target + PC_STEP; valid_q <= 1. The instruction currently in if_* is wrong-path: if_valid must be forced to 0 in the redirect cycle itself (if_valid = valid_q & ~branch_taken & ~jump).
  - jump (no branch_taken): same behaviour with the jump target.
  - stall (no redirect): pc, pc_q and valid_q hold; fetch_count does not increment.
  - Normal: pc_q <= pc; pc <= pc + PC_STEP; valid_q <= 1.
- fetch_count increments by 1 on every edge where if_valid=1 and stall=0, including the cycle an accepted instruction coincides with no redirect. It wraps from 32'hFFFF_FFFF to 0.
- PC arithmetic is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- misaligned sets on any edge where the selected redirect target has nonzero [1:0]. It clears only on reset.
- First cycle after reset release: address = RESET_PC. One cycle later: if_pc = RESET_PC, if_valid = 1.
- Steady-state throughput: one instruction per cycle. Redirect penalty: one bubble, the squashed slot.

Test Plan:
- Reset then run 4 cycles, memory model with 1-cycle latency, RESET_PC=0 -> if_pc sequence 0,4,8,C with if_valid=1 from the 2nd cycle; fetch_count=4 after the 4th accept.
- Stall held 3 cycles while if_pc=8 -> address=8 each stalled cycle; if_pc=8 and if_instruction unchanged; fetch_count frozen; resumes with if_pc=C.
- branch_taken=1, branch_target=0x20 while if_pc=0xC -> if_valid=0 that cycle; next cycle if_pc=0x20, if_valid=1; then 0x24.
- branch_taken=1 (target 0x40) and jump=1 (target 0x80) together, with stall=1 -> branch wins; next if_pc=0x40, valid.
- jump_target=0x13 -> next if_pc=0x10; misaligned=1 and stays 1 until rst_n low.
- Assert rst_n low mid-stall with pc=0x30 -> outputs return to reset values asynchronously before the next clk edge; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// aligns the registered read data into a {pc, instruction, valid} triple for decode.
`timescale 1ns/1ps
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] address,
  input  logic [31:0] instruction_in,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instruction,
  output logic        if_valid,
  output logic        misaligned,
  output logic [31:0] fetch_count
);

  logic [31:0] pc;
  logic [31:0] pc_q;
  logic        valid_q;
  logic        redirect;
  logic [31:0] raw_target;
  logic [31:0] target;

  // Branch outranks jump; the low address bits are dropped so the memory always sees a word address.
  always_comb begin
    redirect   = branch_taken | jump;
    raw_target = branch_taken ? branch_target : jump_target;
    target     = {raw_target[31:2], 2'b00};
  end

  // During a stall the held word is re-read so it is still on instruction_in next cycle.
  always_comb begin
    address = pc;
    if (redirect) begin
      address = target;
    end else if (stall) begin
      address = pc_q;
    end
  end

  assign if_pc          = pc_q;
  assign if_pc_plus4    = pc_q + 32'd4;
  assign if_instruction = instruction_in;
  assign if_valid       = valid_q & ~redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      pc_q        <= RESET_PC;
      valid_q     <= 1'b0;
      misaligned  <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      if (redirect) begin
        pc_q    <= target;
        pc      <= target + PC_STEP;
        valid_q <= 1'b1;
        if (raw_target[1:0] != 2'b00) begin
          misaligned <= 1'b1;
        end
      end else if (!stall) begin
        pc_q    <= pc;
        pc      <= pc + PC_STEP;
        valid_q <= 1'b1;
      end
      if (if_valid && !stall) begin
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule
